// File: rtl/n_addsub_seq_pkg.sv
// n_addsub_seq_pkg: shared state encoding and mode constants for the digit-serial adder/subtractor
package n_addsub_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/n_addsub_seq_digit_addsub.sv
// digit_addsub: combinational K-bit ripple of full-adder cells, exposing the carry into the top bit
module digit_addsub #(
  parameter int K = 1
) (
  input  logic [K-1:0] x,
  input  logic [K-1:0] y,
  input  logic         cin,
  output logic [K-1:0] s,
  output logic         cout,
  output logic         c_msb
);
  logic [K:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < K; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
  assign cout  = c[K];
  assign c_msb = c[K-1];
endmodule

// File: rtl/n_addsub_seq.sv
// n_addsub_seq: multi-cycle N-bit adder/subtractor, K bits per clock LSB digit first, with status flags
module n_addsub_seq
  import n_addsub_seq_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] y,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);
  localparam int D  = N / K;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  if (K < 1 || K > N || N % K != 0) begin : g_bad_k
    $error("n_addsub_seq: K must satisfy 1 <= K <= N and N %% K == 0");
  end
  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d, r_q, r_d, y_q, y_d, r_next;
  logic           carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [K-1:0]   s;
  logic           s_cout, s_cmsb, load, run, last, fin;
  digit_addsub #(.K(K)) u_digit (
    .x    (a_q[K-1:0]),
    .y    (b_q[K-1:0]),
    .cin  (carry_q),
    .s    (s),
    .cout (s_cout),
    .c_msb(s_cmsb)
  );
  if (K == N) begin : g_full
    assign r_next = s;
  end else begin : g_part
    assign r_next = {s, r_q[N-1:K]};
  end
  assign load = start && state_q != RUN;
  assign run  = state_q == RUN;
  assign last = cnt_q == CW'(D - 1);
  assign fin  = run && last;
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  // Next state: start wins from IDLE/DONE, RUN leaves after the last digit
  always_comb state_d = load ? RUN : run ? (last ? DONE : RUN) : IDLE;
  // Handshake outputs decoded from state
  always_comb begin
    busy = state_q == RUN;
    done = state_q == DONE;
  end
  // Datapath next values: load operands, shift one digit per RUN cycle, capture flags on the last digit
  always_comb begin
    a_d     = load ? a : run ? a_q >> K : a_q;
    b_d     = load ? ((mode == MODE_ADD) ? b : ~b) : run ? b_q >> K : b_q;
    carry_d = load ? (mode == MODE_SUB) : run ? s_cout : carry_q;
    cnt_d   = load ? '0 : run ? cnt_q + 1'b1 : cnt_q;
    r_d     = run ? r_next : r_q;
    y_d     = fin ? r_next : y_q;
    cout_d  = fin ? s_cout : cout_q;
    ovf_d   = fin ? s_cout ^ s_cmsb : ovf_q;
    zero_d  = fin ? r_next == '0 : zero_q;
  end
  // Datapath and result/flag registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      y_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  assign y    = y_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
endmodule
